// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-to-1 stream multiplexer: mode encodings and
// the cyclic round-robin search used by the arbiter.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count handled by rr_next.
  localparam int MAX_CH    = 32;
  localparam int MAX_SEL_W = 5;

  // Cyclic search of valid starting at ptr+1 over num_ch channels.
  // Returns the first set index, or -1 when no bit is set.
  // ptr must be below num_ch.
  function automatic int rr_next(
    input logic [MAX_CH-1:0]    valid,
    input logic [MAX_SEL_W-1:0] ptr,
    input int                   num_ch
  );
    int result;
    int cand;
    result = -1;
    for (int k = 1; k <= MAX_CH; k++) begin
      cand = int'(ptr) + k;
      cand = (cand >= num_ch) ? (cand - num_ch) : cand;
      if ((k <= num_ch) && (result < 0) && (cand < MAX_CH)) begin
        if (valid[cand]) begin
          result = cand;
        end else begin
          result = result;
        end
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// found when searching cyclically from ptr+1.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  logic [MAX_CH-1:0]    req_ext_s;
  logic [MAX_SEL_W-1:0] ptr_ext_s;
  int                   idx_s;

  // Widen the request/pointer to the package search width and run the search.
  always_comb begin
    req_ext_s               = '0;
    req_ext_s[NUM_CH-1:0]   = req;
    ptr_ext_s               = '0;
    ptr_ext_s[SEL_W-1:0]    = ptr;
    idx_s                   = rr_next(req_ext_s, ptr_ext_s, NUM_CH);
    if (idx_s >= 0) begin
      grant_valid = 1'b1;
      grant       = SEL_W'(idx_s);
    end else begin
      grant_valid = 1'b0;
      grant       = '0;
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// Registered N-to-1 valid/ready stream multiplexer with fixed-select and
// round-robin modes and a single output register stage.
module stream_mux_nto1
  import stream_mux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     mode_in,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  output logic [NUM_CH-1:0]        ready_out,
  output logic [DATA_W-1:0]        y_out,
  output logic                     y_valid_out,
  input  logic                     y_ready_in,
  output logic [SEL_W-1:0]         ch_out
);

  // Reset value of the round-robin pointer: last channel, so the first
  // search begins at channel 0.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_CH - 1);

  logic [DATA_W-1:0] y_r;
  logic [SEL_W-1:0]  ch_r;
  logic              y_valid_r;
  logic [SEL_W-1:0]  rr_ptr_r;

  logic              load_en_s;
  logic [SEL_W-1:0]  rr_grant_s;
  logic              rr_grant_valid_s;
  logic              fixed_valid_s;
  logic [SEL_W-1:0]  grant_s;
  logic              grant_valid_s;
  logic [DATA_W-1:0] next_data_s;

  assign y_out       = y_r;
  assign ch_out      = ch_r;
  assign y_valid_out = y_valid_r;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req         (valid_in),
    .ptr         (rr_ptr_r),
    .grant       (rr_grant_s),
    .grant_valid (rr_grant_valid_s)
  );

  // Register may accept a word when empty or when its word drains this
  // cycle; never during reset so no transfer is acknowledged then.
  always_comb begin
    load_en_s = rst_n_in && (!y_valid_r || y_ready_in);
  end

  // Fixed-select grant: only an in-range, valid channel is granted. The
  // equality scan makes out-of-range selects resolve to no grant.
  always_comb begin
    fixed_valid_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_in == SEL_W'(i)) begin
        fixed_valid_s = valid_in[i];
      end else begin
        fixed_valid_s = fixed_valid_s;
      end
    end
  end

  // Mode select between fixed and round-robin grant.
  always_comb begin
    if (mode_in == MODE_RR) begin
      grant_s       = rr_grant_s;
      grant_valid_s = rr_grant_valid_s;
    end else begin
      grant_s       = sel_in;
      grant_valid_s = fixed_valid_s;
    end
  end

  // One-hot ready toward the granted producer only.
  always_comb begin
    ready_out = '0;
    if (load_en_s && grant_valid_s) begin
      ready_out[grant_s] = 1'b1;
    end else begin
      ready_out = '0;
    end
  end

  // Data word of the granted channel.
  always_comb begin
    next_data_s = '0;
    if (grant_valid_s) begin
      next_data_s = data_in[int'(grant_s)*DATA_W +: DATA_W];
    end else begin
      next_data_s = '0;
    end
  end

  // Output register: load on transfer, empty when loadable with no grant,
  // hold under back-pressure.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      y_r       <= '0;
      ch_r      <= '0;
      y_valid_r <= 1'b0;
    end else if (load_en_s) begin
      if (grant_valid_s) begin
        y_r       <= next_data_s;
        ch_r      <= grant_s;
        y_valid_r <= 1'b1;
      end else begin
        y_valid_r <= 1'b0;
      end
    end
  end

  // Round-robin pointer follows the last round-robin transfer only.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      rr_ptr_r <= PTR_RST;
    end else if (load_en_s && grant_valid_s && (mode_in == MODE_RR)) begin
      rr_ptr_r <= grant_s;
    end
  end

endmodule
